// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-entry hold buffer so that
// consecutive words leave back to back with no idle bit-times between frames.
module piso_tx #(
  parameter int WIDTH     = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load,
  output logic             ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [WIDTH-1:0] hold_reg, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic             s_out_nxt, s_valid_nxt, frame_start_nxt;

  logic             accept;
  logic             last_bit;
  logic             launch;
  logic [WIDTH-1:0] launch_word;
  logic [WIDTH-1:0] shifted;

  // ready depends only on registered state so upstream never sees a load->ready loop.
  assign ready    = !hold_full;
  assign busy     = (state == SHIFT) || hold_full;
  assign accept   = load && ready;
  assign last_bit = (bit_cnt == LAST_BIT);

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // The register always holds the bit currently on s_out in its first-bit position.
  assign shifted = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], 1'b0}
                                    : {1'b0, shift_reg[WIDTH-1:1]};

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    state_nxt       = state;
    shift_nxt       = shift_reg;
    hold_nxt        = hold_reg;
    hold_full_nxt   = hold_full;
    cnt_nxt         = bit_cnt;
    s_out_nxt       = s_out;
    s_valid_nxt     = s_valid;
    frame_start_nxt = 1'b0;
    launch          = 1'b0;
    launch_word     = '0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          launch      = 1'b1;
          launch_word = p_in;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (hold_full) begin
            launch        = 1'b1;
            launch_word   = hold_reg;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            // Bypass the hold buffer so a word offered on the last-bit edge streams without a gap.
            launch      = 1'b1;
            launch_word = p_in;
          end else begin
            state_nxt   = IDLE;
            shift_nxt   = '0;
            cnt_nxt     = '0;
            s_out_nxt   = 1'b0;
            s_valid_nxt = 1'b0;
          end
        end else begin
          shift_nxt = shifted;
          cnt_nxt   = bit_cnt + 1'b1;
          s_out_nxt = first_bit(shifted);
          if (accept) begin
            hold_nxt      = p_in;
            hold_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (launch) begin
      state_nxt       = SHIFT;
      shift_nxt       = launch_word;
      cnt_nxt         = '0;
      s_out_nxt       = first_bit(launch_word);
      s_valid_nxt     = 1'b1;
      frame_start_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      s_out       <= 1'b0;
      s_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_nxt;
      shift_reg   <= shift_nxt;
      hold_reg    <= hold_nxt;
      hold_full   <= hold_full_nxt;
      bit_cnt     <= cnt_nxt;
      s_out       <= s_out_nxt;
      s_valid     <= s_valid_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first instance for most scenarios and an
// LSB-first instance for bit ordering.
module tb_piso_tx;

  localparam int WIDTH = 3;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] p_in;
  logic             load;
  logic             ready, s_out, s_valid, frame_start, busy;

  logic [WIDTH-1:0] p_in_l;
  logic             load_l;
  logic             ready_l, s_out_l, s_valid_l, frame_start_l, busy_l;

  int vectors;
  int miscompares;

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_in        (p_in),
    .load        (load),
    .ready       (ready),
    .s_out       (s_out),
    .s_valid     (s_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
    .clk         (clk),
    .reset       (reset),
    .p_in        (p_in_l),
    .load        (load_l),
    .ready       (ready_l),
    .s_out       (s_out_l),
    .s_valid     (s_valid_l),
    .frame_start (frame_start_l),
    .busy        (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b1; p_in = 3'b111;
    load_l = 1'b1; p_in_l = 3'b111;
    #8;  // one rising edge has passed with load high
    vectors++;
    if ({s_out, s_valid, frame_start, busy} !== 4'b0000) begin
      $display("FAIL reset_outputs: got %b want 0000", {s_out, s_valid, frame_start, busy});
      miscompares++;
    end
    vectors++;
    if ({s_out_l, s_valid_l, frame_start_l, busy_l} !== 4'b0000) begin
      $display("FAIL reset_outputs_lsb: got %b want 0000",
               {s_out_l, s_valid_l, frame_start_l, busy_l});
      miscompares++;
    end
    #2;
    load = 1'b0; load_l = 1'b0; p_in = 'x; p_in_l = 'x;
    reset = 1'b1;
    tick();
    vectors++;
    if ({ready, busy, s_valid} !== 3'b100) begin
      $display("FAIL reset_release: ready/busy/s_valid got %b want 100", {ready, busy, s_valid});
      miscompares++;
    end
  endtask

  task automatic test_single();
    logic [2:0] exp_bits;
    exp_bits = 3'b101;  // MSB first: 1,0,1
    p_in = 3'b101; load = 1'b1;
    tick();
    load = 1'b0; p_in = 'x;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({s_out, s_valid, frame_start, busy} !== {exp_bits[2-i], 1'b1, (i == 0), 1'b1}) begin
        $display("FAIL single_bit%0d: out/valid/fs/busy got %b want %b", i,
                 {s_out, s_valid, frame_start, busy}, {exp_bits[2-i], 1'b1, (i == 0), 1'b1});
        miscompares++;
      end
      tick();
    end
    vectors++;
    if ({s_out, s_valid, frame_start, busy, ready} !== 5'b00001) begin
      $display("FAIL single_done: out/valid/fs/busy/ready got %b want 00001",
               {s_out, s_valid, frame_start, busy, ready});
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_out, exp_fs, exp_rdy;
    exp_out = 6'b110011;
    exp_fs  = 6'b100100;
    exp_rdy = 6'b100111;
    p_in = 3'b110; load = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({s_out, frame_start, ready, s_valid, busy} !==
          {exp_out[5-i], exp_fs[5-i], exp_rdy[5-i], 2'b11}) begin
        $display("FAIL b2b_bit%0d: out/fs/ready/valid/busy got %b want %b", i,
                 {s_out, frame_start, ready, s_valid, busy},
                 {exp_out[5-i], exp_fs[5-i], exp_rdy[5-i], 2'b11});
        miscompares++;
      end
      if (i == 0) p_in = 3'b011;
      if (i == 1) p_in = 3'b111;  // offered while ready=0; must be ignored
      if (i == 3) begin load = 1'b0; p_in = 'x; end
      tick();
    end
    vectors++;
    if ({s_valid, busy} !== 2'b00) begin
      $display("FAIL b2b_done: valid/busy got %b want 00", {s_valid, busy});
      miscompares++;
    end
  endtask

  task automatic test_bypass();
    logic [5:0] exp_out, exp_fs;
    exp_out = 6'b111100;
    exp_fs  = 6'b100100;
    p_in = 3'b111; load = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({s_out, frame_start, ready, s_valid} !== {exp_out[5-i], exp_fs[5-i], 2'b11}) begin
        $display("FAIL bypass_bit%0d: out/fs/ready/valid got %b want %b", i,
                 {s_out, frame_start, ready, s_valid}, {exp_out[5-i], exp_fs[5-i], 2'b11});
        miscompares++;
      end
      if (i == 0) begin load = 1'b0; p_in = 'x; end
      if (i == 2) begin load = 1'b1; p_in = 3'b100; end
      if (i == 3) begin load = 1'b0; p_in = 'x; end
      tick();
    end
    vectors++;
    if ({s_valid, busy, s_out} !== 3'b000) begin
      $display("FAIL bypass_done: valid/busy/out got %b want 000", {s_valid, busy, s_out});
      miscompares++;
    end
  endtask

  task automatic test_lsb_first();
    logic [2:0] exp_seq;
    exp_seq = 3'b011;  // word 110 sent LSB first: 0,1,1
    p_in_l = 3'b110; load_l = 1'b1;
    tick();
    load_l = 1'b0; p_in_l = 'x;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({s_out_l, s_valid_l, frame_start_l} !== {exp_seq[2-i], 1'b1, (i == 0)}) begin
        $display("FAIL lsb_bit%0d: out/valid/fs got %b want %b", i,
                 {s_out_l, s_valid_l, frame_start_l}, {exp_seq[2-i], 1'b1, (i == 0)});
        miscompares++;
      end
      tick();
    end
    vectors++;
    if ({s_valid_l, busy_l} !== 2'b00) begin
      $display("FAIL lsb_done: valid/busy got %b want 00", {s_valid_l, busy_l});
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] exp_seq;
    exp_seq = 3'b011;
    p_in = 3'b101; load = 1'b1;
    tick();
    p_in = 3'b010;  // captured into the hold buffer on the next edge
    tick();
    load = 1'b0; p_in = 'x;
    vectors++;
    if ({s_out, ready, busy} !== 3'b001) begin
      $display("FAIL mid_hold: out/ready/busy got %b want 001", {s_out, ready, busy});
      miscompares++;
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({s_out, s_valid, frame_start, busy, ready} !== 5'b00001) begin
      $display("FAIL mid_async_clear: out/valid/fs/busy/ready got %b want 00001",
               {s_out, s_valid, frame_start, busy, ready});
      miscompares++;
    end
    #2 reset = 1'b1;
    p_in = 3'b011; load = 1'b1;
    tick();
    load = 1'b0; p_in = 'x;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({s_out, s_valid} !== ((i < 3) ? {exp_seq[2-i], 1'b1} : 2'b00)) begin
        $display("FAIL mid_after_bit%0d: out/valid got %b want %b", i,
                 {s_out, s_valid}, ((i < 3) ? {exp_seq[2-i], 1'b1} : 2'b00));
        miscompares++;
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bypass();
    test_lsb_first();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter that sits directly upstream of the sipo deserializer and drives its s_in. It accepts parallel words through a valid/ready handshake and shifts each word out one bit per clock. A one-entry holding buffer lets consecutive words stream with no idle bit-times between frames. s_out can be wired straight to sipo s_in for loopback.

Parameters:
WIDTH, 3, word width in bits; must be >= 2; matches the sipo p_out width.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous active-low reset (0 = reset asserted).
p_in  input  WIDTH  parallel word to transmit.
load  input  1  p_in valid.
ready  output  1  block can accept a word this cycle.
s_out  output  1  serial data; registered.
s_valid  output  1  s_out carries a data bit this cycle; registered.
frame_start  output  1  high only during the first bit of each frame; registered.
busy  output  1  high when a frame is in progress or a word is held.

Behaviour:
- Reset (reset=0, asynchronous): s_out=0, s_valid=0, frame_start=0, busy=0, shift register=0, bit counter=0, hold buffer empty, state=IDLE. ready=1 once reset is released. load is ignored while reset=0.
- Accept: a word is accepted on a rising edge where load=1 and ready=1. p_in is not sampled when load=0, so X on p_in must never reach any state.
- ready = !hold_full; combinational from registered state only, with no path from load.
- States: IDLE and SHIFT.
  - IDLE: on accept, load the shift register with p_in, set bit_cnt=0, s_valid=1, frame_start=1, and go to SHIFT. The first bit appears on s_out in the cycle after the accept edge, giving a latency of 1 clock.
  - SHIFT: each edge advances by one bit and increments bit_cnt. frame_start=0 after the first bit. s_out carries the word MSB-first (or LSB-first when MSB_FIRST=0).
  - An accept while in SHIFT writes the word into the hold buffer, setting hold_full=1.
- Last-bit edge (bit_cnt==WIDTH-1) in SHIFT:
  - Hold full: hold moves into the shift register, hold empties, bit_cnt=0, frame_start=1, s_valid stays 1.
  - Hold empty and an accept occurs on this edge: p_in bypasses straight into the shift register with the same effect as above.
  - Otherwise: s_valid=0, s_out=0, go to IDLE.
- Sustained throughput is one word per WIDTH clocks. s_valid has no gap between back-to-back frames.
- busy = (state==SHIFT) | hold_full.
- A word accepted into the hold buffer is never dropped or overwritten, because ready=0 while the hold buffer is full.
- Reset mid-frame aborts the frame, discards any held word and returns to reset values immediately.
- In IDLE, s_out and frame_start are 0 and the hold buffer is empty.

Test Plan:
- Reset: reset=0 for 10 ns with load=1 and p_in=3'b111 -> all outputs 0 and nothing captured; after release, ready=1 and busy=0.
- Single word: 3'b101 accepted at edge N -> s_out=1,0,1 in cycles N+1..N+3; s_valid=1 for exactly those 3 cycles; frame_start=1 only in N+1; then s_valid=0 and busy=0.
- Back-to-back: load held high with 3'b110 then 3'b011 -> the second word is held and ready=0 until the last-bit edge of frame 1; s_out=1,1,0,0,1,1 over 6 contiguous cycles; frame_start high on bits 1 and 4; s_valid never drops.
- Bypass: frame 3'b111 in flight, hold empty, 3'b100 loaded exactly at its last-bit edge -> s_out=1,1,1,1,0,0 contiguous; hold never set.
- LSB-first: MSB_FIRST=0, word 3'b110 -> s_out=0,1,1.
- Reset mid-frame: assert reset after 2 bits of 3'b101 with 3'b010 held -> outputs clear asynchronously. After release, 3'b011 transmits cleanly as 0,1,1 and the held 3'b010 never appears.
